// File: rtl/pwm_rtl_pkg.sv
// Shared types for the PWM generator: operating mode and default width.
package pwm_rtl_pkg;

  localparam int PWM_DEFAULT_WIDTH = 8;

  typedef enum logic {
    MODE_IDLE = 1'b0,
    MODE_RUN  = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter: counts 0..div_act-1 and restarts on every load strobe.
module pwm_period_counter
  import pwm_rtl_pkg::*;
#(
  parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div_act,
  input  logic             load,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  pwm_mode_e        mode;

  assign mode = (div_act != '0) ? MODE_RUN : MODE_IDLE;

  // div_act-1 is only looked at in MODE_RUN, so it cannot underflow.
  assign tc = (mode == MODE_RUN) && (cnt_q == (div_act - WIDTH'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (load || (mode == MODE_IDLE) || tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_rtl.sv
// PWM generator top: active settings, boundary-only accept logic and output compare.
module pwm_rtl
  import pwm_rtl_pkg::*;
#(
  parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_valid,
  output logic             ready,
  output logic             out
);

  // Handshake: settings are taken on any rising edge where ready=1; div_valid
  // and duty_valid are sampled independently there and never influence ready.

  logic [WIDTH-1:0] div_act_q;
  logic [WIDTH-1:0] div_act_d;
  logic [WIDTH-1:0] duty_act_q;
  logic [WIDTH-1:0] duty_act_d;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             load;
  pwm_mode_e        mode;

  assign mode  = (div_act_q != '0) ? MODE_RUN : MODE_IDLE;
  assign ready = (mode == MODE_IDLE) || tc;
  assign load  = ready;

  pwm_period_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_act(div_act_q),
    .load   (load),
    .cnt    (cnt),
    .tc     (tc)
  );

  always_comb begin
    div_act_d  = div_act_q;
    duty_act_d = duty_act_q;
    if (load) begin
      // A zero period request is dropped; the duty request stands on its own.
      if (div_valid && (div != '0)) begin
        div_act_d = div;
      end
      if (duty_valid) begin
        duty_act_d = duty;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act_q  <= '0;
      duty_act_q <= '0;
    end else begin
      div_act_q  <= div_act_d;
      duty_act_q <= duty_act_d;
    end
  end

  assign out = (mode == MODE_RUN) && (cnt < duty_act_q);

endmodule

// File: tb/tb_pwm_rtl.sv
// Bench for pwm_rtl at WIDTH=4: vector table, directed corner sequences, random run.
module tb_pwm_rtl;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] div;
  logic         div_valid;
  logic [W-1:0] duty;
  logic         duty_valid;
  logic         ready;
  logic         pwm_out;

  int total = 0;
  int bad   = 0;

  pwm_rtl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .div       (div),
    .div_valid (div_valid),
    .duty      (duty),
    .duty_valid(duty_valid),
    .ready     (ready),
    .out       (pwm_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Waveform described by time: a period of length m_div starts at cycle m_t0.
  int m_t    = 0;
  int m_t0   = 0;
  int m_div  = 0;
  int m_duty = 0;
  logic [1:0] exp_q[$];

  function automatic int m_cnt();
    return (m_div == 0) ? 0 : (m_t - m_t0) % m_div;
  endfunction

  function automatic logic m_ready();
    return (m_div == 0) || (m_cnt() == m_div - 1);
  endfunction

  function automatic logic m_out();
    return (m_div != 0) && (m_cnt() < m_duty);
  endfunction

  task automatic model_edge();
    if (m_ready()) begin
      if (div_valid && (div != '0)) m_div = int'(div);
      if (duty_valid) m_duty = int'(duty);
      m_t0 = m_t + 1;
    end
    m_t = m_t + 1;
    exp_q.push_back({m_ready(), m_out()});
  endtask

  task automatic model_reset();
    m_div  = 0;
    m_duty = 0;
    m_t0   = m_t;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      cmp("model_queue_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    cmp("model_ready", int'(ready), int'(e[1]));
    cmp("model_out", int'(pwm_out), int'(e[0]));
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input int d, input bit dv, input int u, input bit uv);
    div        = W'(d);
    div_valid  = dv;
    duty       = W'(u);
    duty_valid = uv;
  endtask

  // Inputs are already set; advance one edge and check at posedge+1.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Wait for a boundary, let it load, then count high cycles over p cycles.
  task automatic period_highs(input int p, output int highs);
    int n = 0;
    highs = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    if (!ready) cmp("boundary_timeout", 0, 1);
    tick();
    highs = int'(pwm_out);
    for (int i = 1; i < p; i++) begin
      tick();
      highs += int'(pwm_out);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] d;
    logic         dv;
    logic [W-1:0] u;
    logic         uv;
    logic         er;
    logic         eo;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input int d, input bit dv, input int u, input bit uv,
                              input bit er, input bit eo);
    vec_t v;
    v.d = W'(d); v.dv = dv; v.u = W'(u); v.uv = uv; v.er = er; v.eo = eo;
    return v;
  endfunction

  initial begin
    int h;
    int n;
    int plen;

    drive(0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    cmp("reset_ready", int'(ready), 1);
    cmp("reset_out", int'(pwm_out), 0);
    @(posedge clk);
    #1;
    cmp("reset_hold_ready", int'(ready), 1);
    rst_n = 1'b1;
    model_reset();

    // Each row: inputs applied before the edge, outputs expected after it.
    vecs[0]  = mk(10, 1, 5, 1, 0, 1);  // load 10/5, cnt 0
    vecs[1]  = mk(10, 0, 5, 0, 0, 1);
    vecs[2]  = mk(10, 0, 5, 0, 0, 1);
    vecs[3]  = mk(10, 0, 5, 0, 0, 1);
    vecs[4]  = mk(10, 0, 5, 0, 0, 1);  // cnt 4
    vecs[5]  = mk(10, 0, 5, 0, 0, 0);  // cnt 5
    vecs[6]  = mk(3,  1, 9, 1, 0, 0);  // not ready: ignored
    vecs[7]  = mk(10, 0, 5, 0, 0, 0);
    vecs[8]  = mk(10, 0, 5, 0, 0, 0);
    vecs[9]  = mk(1,  1, 0, 1, 1, 0);  // cnt 9, terminal
    vecs[10] = mk(1,  1, 0, 1, 1, 0);  // loaded div=1 duty=0
    vecs[11] = mk(0,  1, 1, 1, 1, 1);  // div=0 rejected, duty=1 taken
    vecs[12] = mk(0,  0, 0, 1, 1, 0);  // duty back to 0
    vecs[13] = mk(4,  1, 2, 1, 0, 1);  // 4/2, cnt 0
    for (int i = 0; i < 14; i++) begin
      drive(int'(vecs[i].d), vecs[i].dv, int'(vecs[i].u), vecs[i].uv);
      tick();
      cmp($sformatf("vec%0d_ready", i), int'(ready), int'(vecs[i].er));
      cmp($sformatf("vec%0d_out", i), int'(pwm_out), int'(vecs[i].eo));
    end

    // Scenario 1: 10/5 steady.
    do_reset();
    drive(10, 1, 5, 1);
    tick();
    period_highs(10, h);
    cmp("s1_highs", h, 5);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n += int'(ready);
    end
    cmp("s1_ready_count", n, 2);

    // Scenario 2: duty 5->7 requested mid-period at cnt 3.
    drive(10, 0, 5, 0);
    n = 0;
    while (m_cnt() != 3 && n < 20) begin
      tick();
      n++;
    end
    drive(10, 0, 7, 1);
    h = int'(pwm_out);
    for (int i = 0; i < 6; i++) begin
      tick();
      h += int'(pwm_out);
    end
    cmp("s2_old_period_tail_highs", h, 2);
    period_highs(10, h);
    cmp("s2_new_highs", h, 7);

    // Scenario 3: pending values ignored without valids.
    drive(15, 0, 6, 0);
    for (int i = 0; i < 25; i++) tick();
    period_highs(10, h);
    cmp("s3_no_valid_highs", h, 7);
    drive(15, 1, 6, 1);
    period_highs(15, h);
    cmp("s3_new_highs", h, 6);

    // Scenario 4: 0% then 100%.
    drive(10, 1, 0, 1);
    period_highs(10, h);
    cmp("s4_zero_duty", h, 0);
    drive(12, 1, 12, 1);
    period_highs(12, h);
    cmp("s4_full_duty", h, 12);
    n = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n += int'(ready);
    end
    cmp("s4_ready_count", n, 2);

    // Scenario 5: div=1 keeps ready high, then reload 10/5.
    drive(1, 1, 0, 1);
    period_highs(1, h);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n += int'(ready);
      h += int'(pwm_out);
    end
    cmp("s5_ready_stuck", n, 5);
    cmp("s5_out_low", h, 0);
    drive(10, 1, 5, 1);
    tick();
    cmp("s5_reload_ready", int'(ready), 0);
    cmp("s5_reload_out", int'(pwm_out), 1);
    period_highs(10, h);
    cmp("s5_highs", h, 5);

    // Scenario 6: div=0 rejected, then asynchronous reset mid-period.
    drive(0, 1, 5, 0);
    period_highs(1, h);
    plen = 1;
    while (!ready && plen < 40) begin
      tick();
      plen++;
    end
    cmp("s6_period_kept", plen, 10);
    drive(10, 1, 5, 1);
    tick();
    tick();
    tick();
    cmp("s6_pre_reset_out", int'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    cmp("s6_async_out", int'(pwm_out), 0);
    cmp("s6_async_ready", int'(ready), 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    cmp("s6_first_after_reset_out", int'(pwm_out), 1);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      drive(int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
